// File: rtl/rfid_tag_reader.sv
// Serial RFID frame receiver: start/8 data LSB-first/even parity/stop framing,
// presents the tag ID to the lock controller and waits for its verdict.
module rfid_tag_reader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned RESP_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tag_rx,
    input  logic       door_unlock,
    input  logic       access_denied,
    output logic [7:0] rfid_data,
    output logic       valid,
    output logic       busy,
    output logic       frame_error,
    output logic       grant_seen,
    output logic       deny_seen,
    output logic       resp_timeout
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, SEND, WAIT_RESP
    } state_t;

    state_t        state;
    logic          sync1, rx_s, rx_prev;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    shift_reg;
    logic          parity_ok;

    // Two-flop synchronizer plus a registered previous sample for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= tag_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            tmo_cnt      <= '0;
            shift_reg    <= '0;
            parity_ok    <= 1'b0;
            rfid_data    <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            frame_error  <= 1'b0;
            grant_seen   <= 1'b0;
            deny_seen    <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            valid        <= 1'b0;
            frame_error  <= 1'b0;
            grant_seen   <= 1'b0;
            deny_seen    <= 1'b0;
            resp_timeout <= 1'b0;
            bit_cnt      <= bit_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt   <= '0;
                        parity_ok <= (rx_s == ^shift_reg);
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt <= '0;
                        if (rx_s && parity_ok) begin
                            rfid_data <= shift_reg;
                            valid     <= 1'b1;
                            state     <= SEND;
                        end else begin
                            frame_error <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                SEND: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    // Denial wins over a simultaneous grant so the door stays shut
                    if (access_denied) begin
                        deny_seen <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (door_unlock) begin
                        grant_seen <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (tmo_cnt == TMO_M1) begin
                        resp_timeout <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rfid_tag_reader.md
# rfid_tag_reader

Front-end for the smart door access path. Receives the serial frame a card or tag sends over a single-wire line, checks it, and presents the 8-bit tag ID to the door lock controller as `rfid_data` with a one-cycle `valid` strobe. It then waits for the lock's verdict, `door_unlock` or `access_denied`, before it accepts another card. A response timeout stops the reader from hanging if the lock never answers.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Even, ≥ 4.
- `RESP_TIMEOUT`, default 8: maximum cycles to wait for a lock verdict after `valid`. ≥ 1.
- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-high.
- `tag_rx`  input  1  asynchronous serial line. Idles high.
- `door_unlock`  input  1  lock verdict: granted.
- `access_denied`  input  1  lock verdict: denied.
- `rfid_data`  output  8  last accepted tag ID. Held stable until the next accepted frame.
- `valid`  output  1  one-cycle strobe: `rfid_data` is new.
- `busy`  output  1  high in every state except IDLE.
- `frame_error`  output  1  one-cycle pulse: parity or stop-bit failure.
- `grant_seen`  output  1  one-cycle pulse: `door_unlock` received in WAIT_RESP.
- `deny_seen`  output  1  one-cycle pulse: `access_denied` received in WAIT_RESP.
- `resp_timeout`  output  1  one-cycle pulse: no verdict within `RESP_TIMEOUT`.

## Operation
- Frame format: start bit 0, then 8 data bits LSB first, then even-parity bit, then stop bit 1. The parity bit is the XOR of the 8 data bits.
- `tag_rx` passes through a 2-flop synchronizer before any use. Both flops reset to 1. All descriptions below refer to the synchronized value `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP, SEND, WAIT_RESP.
- IDLE: a high-to-low transition of `rx_s` moves to START and clears the bit-period counter. This requires a registered previous sample.
- START: count `CLKS_PER_BIT/2` cycles to mid-bit.
  - If `rx_s` = 0, go to DATA.
  - Otherwise the edge was a glitch. Go to IDLE silently, with no `frame_error`.
- DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit 7 and shift right. After the 8th sample, go to PARITY.
- PARITY: after `CLKS_PER_BIT` cycles, sample the parity bit and compare it with the XOR of the shift register. Go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample the stop bit.
  - If stop = 1 and parity is good: load `rfid_data` from the shift register and go to SEND.
  - Otherwise: pulse `frame_error` and go to IDLE. `rfid_data` is unchanged.
- SEND: `valid` = 1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_RESP.
- WAIT_RESP: the counter increments each cycle.
  - `access_denied` = 1: pulse `deny_seen`, go to IDLE. This takes priority when both verdict inputs are high together (fail-safe).
  - Else `door_unlock` = 1: pulse `grant_seen`, go to IDLE.
  - Else the counter reaches `RESP_TIMEOUT`: pulse `resp_timeout`, go to IDLE.
- `door_unlock` and `access_denied` are ignored in every state except WAIT_RESP.
- Serial activity during SEND and WAIT_RESP is ignored, and any frame in progress is lost. A new frame is recognized only after IDLE sees a fresh high-to-low edge.
- Counter widths:
  - Bit-period counter: `$clog2(CLKS_PER_BIT)`.
  - Bit index: 3 bits.
  - Timeout counter: `$clog2(RESP_TIMEOUT+1)`.
  - No counter wraps within normal use.

## Timing
- Reset values:
  - State IDLE.
  - `rfid_data` = 0x00.
  - `valid`, `busy`, `frame_error`, `grant_seen`, `deny_seen`, `resp_timeout` = 0.
  - Synchronizer flops = 1.
- All outputs are registered or decoded directly from registered state. There is no combinational path from an input to an output.
- Let E be the clock edge at which IDLE first samples `rx_s` = 0 after a 1. Then:
  - START is entered at E+1.
  - Mid-start is sampled `CLKS_PER_BIT/2` cycles after E.
  - Bit k is sampled at E + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`, where k runs over data bits 0–7, then parity, then stop.
  - `valid` is high in the cycle after the stop sample: E + `CLKS_PER_BIT/2` + 10·`CLKS_PER_BIT` + 1. With the default `CLKS_PER_BIT` = 16, that is E+169.
- The pin-to-`rx_s` latency is 2 cycles.
- A verdict is accepted from the first WAIT_RESP cycle, which is the cycle after `valid`.
- Timeout: `resp_timeout` pulses `RESP_TIMEOUT` cycles after WAIT_RESP is entered, and the state is IDLE on the following cycle.
- Reset asserted mid-operation forces IDLE immediately and clears all outputs, including `rfid_data`.
- Pulse outputs never assert together in one cycle.

## Test plan
- Good frame: send ID 0x81 with parity 0 and stop 1 (`CLKS_PER_BIT` = 16). Drive `door_unlock` 3 cycles after `valid`. Required: `rfid_data` = 0x81, `valid` is a single cycle at E+169, `grant_seen` pulses once, `busy` is low afterwards.
- Bad parity: send 0x81 with parity 1. Required: `frame_error` pulses once, `valid` is never asserted, `rfid_data` keeps its prior value.
- Bad stop: send 0x3C with stop 0. Required: `frame_error` pulses once, then a following valid 0x55 frame is accepted.
- Timeout: good frame 0x12 with no verdict (`RESP_TIMEOUT` = 8). Required: `resp_timeout` pulses once, IDLE is reached, and the next frame is accepted.
- Priority and ignore cases:
  - `door_unlock` and `access_denied` both high in WAIT_RESP: only `deny_seen` pulses.
  - Verdicts driven while in IDLE: no pulse.
  - A 3-cycle low glitch on `tag_rx`: no `frame_error`, no `valid`.
- Reset mid-DATA after 4 bits, released, then full frame 0xA5 sent. Required: all outputs are 0 during reset, and 0xA5 is accepted cleanly afterwards.
